// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART echo block.
//   rx_state_t / tx_state_t : receiver and transmitter FSM states
//   IDLE_LEVEL, START_LEVEL, STOP_LEVEL : serial line levels
//   parity_bit() : parity bit for up to MAX_DATA_BITS of payload
package uart_pkg;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_PAR,
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_PAR,
        T_STOP
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    localparam int unsigned MAX_DATA_BITS = 9;

    // Even parity bit is the XOR of the payload; odd parity inverts it.
    // Narrower payloads are zero-extended by the caller.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a combinational read port (dout shows the head entry).
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   push, din     : write request and data; accepted when not full or when popping
//   pop, dout     : read request (ignored when empty) and head data
//   full, empty   : occupancy status
//   count         : occupancy, 0..DEPTH
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A pop frees the slot a same-cycle push needs, so full+push+pop does both.
    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push_c) - CW'(do_pop_c);
        end
    end

    // Storage array, not reset.
    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// UART transceiver that echoes every good received word back out on TxD
// through an on-chip FIFO. Reception is oversampled with a 2-flop synchroniser
// and start-bit glitch rejection; errors are reported on sticky flags.
// Optional feature macro: UART_PARITY_EN adds one parity bit per frame
// (even when PARITY_ODD=0, odd otherwise); without it parity_err is tied 0.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   RxD         : asynchronous serial input, idle high
//   TxD         : serial output, idle high
//   clr_err     : one-cycle pulse clearing all sticky flags
//   frame_err   : sticky, stop bit sampled low
//   rx_overrun  : sticky, word arrived while FIFO full
//   parity_err  : sticky, parity mismatch
//   fifo_count  : FIFO occupancy, 0..FIFO_DEPTH
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned BAUD        = 9600,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned PARITY_ODD  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          RxD,
    output logic                          TxD,
    input  logic                          clr_err,
    output logic                          frame_err,
    output logic                          rx_overrun,
    output logic                          parity_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned DIV = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned DW  = $clog2(DIV);
    localparam int unsigned SW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = $clog2(DATA_BITS);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [SW-1:0] OS_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] OS_HALF  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    // Elaboration-time parameter sanity checks.
    if (DIV < 2) begin : g_bad_div
        $error("uart_echo_fifo: CLK_FREQ_HZ/(BAUD*OVERSAMPLE) must be >= 2");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
        $error("uart_echo_fifo: OVERSAMPLE must be even and >= 4");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > MAX_DATA_BITS)) begin : g_bad_dbits
        $error("uart_echo_fifo: DATA_BITS must be 5..9");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_echo_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_par
        $error("uart_echo_fifo: PARITY_ODD must be 0 or 1");
    end

    // Free-running oversample tick.
    logic [DW-1:0] div_cnt;
    logic          tick_c;

    assign tick_c = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset)       div_cnt <= '0;
        else if (tick_c) div_cnt <= '0;
        else             div_cnt <= div_cnt + DW'(1);
    end

    // RxD synchroniser, reset to the idle level.
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= IDLE_LEVEL;
            rxs     <= IDLE_LEVEL;
        end else begin
            rx_meta <= RxD;
            rxs     <= rx_meta;
        end
    end

    // FIFO between receiver and transmitter.
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 rx_push_c;
    logic                 tx_pop_c;
    logic [DATA_BITS-1:0] rx_sh;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push_c),
        .pop   (tx_pop_c),
        .din   (rx_sh),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Receiver.
    rx_state_t     rx_state;
    logic [SW-1:0] rx_scnt;
    logic [BW-1:0] rx_bcnt;
    logic          rx_stop_pt_c;

    assign rx_stop_pt_c = tick_c && (rx_state == R_STOP) && (rx_scnt == OS_LAST);

`ifdef UART_PARITY_EN
    logic rx_par_bad;
    assign rx_push_c = rx_stop_pt_c && (rxs == STOP_LEVEL) && !rx_par_bad;
`else
    assign rx_push_c  = rx_stop_pt_c && (rxs == STOP_LEVEL);
    assign parity_err = 1'b0;
`endif

    // RX FSM plus sticky flags; a new error in the clr_err cycle wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= R_IDLE;
            rx_scnt    <= '0;
            rx_bcnt    <= '0;
            rx_sh      <= '0;
            frame_err  <= 1'b0;
            rx_overrun <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            if (clr_err) begin
                frame_err  <= 1'b0;
                rx_overrun <= 1'b0;
`ifdef UART_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
            if (rx_push_c && fifo_full && !tx_pop_c) rx_overrun <= 1'b1;

            if (tick_c) begin
                case (rx_state)
                    R_IDLE: begin
                        if (rxs == START_LEVEL) begin
                            rx_state <= R_START;
                            rx_scnt  <= '0;
                        end
                    end
                    R_START: begin
                        if (rx_scnt == OS_HALF) begin
                            rx_scnt  <= '0;
                            rx_bcnt  <= '0;
                            rx_state <= (rxs == IDLE_LEVEL) ? R_IDLE : R_DATA;
                        end else begin
                            rx_scnt <= rx_scnt + SW'(1);
                        end
                    end
                    R_DATA: begin
                        if (rx_scnt == OS_LAST) begin
                            rx_scnt <= '0;
                            rx_sh   <= {rxs, rx_sh[DATA_BITS-1:1]};
                            if (rx_bcnt == BIT_LAST) begin
`ifdef UART_PARITY_EN
                                rx_state <= R_PAR;
`else
                                rx_state <= R_STOP;
`endif
                            end else begin
                                rx_bcnt <= rx_bcnt + BW'(1);
                            end
                        end else begin
                            rx_scnt <= rx_scnt + SW'(1);
                        end
                    end
`ifdef UART_PARITY_EN
                    R_PAR: begin
                        if (rx_scnt == OS_LAST) begin
                            rx_scnt    <= '0;
                            rx_par_bad <= (rxs != parity_bit(MAX_DATA_BITS'(rx_sh), 1'(PARITY_ODD)));
                            if (rxs != parity_bit(MAX_DATA_BITS'(rx_sh), 1'(PARITY_ODD)))
                                parity_err <= 1'b1;
                            rx_state   <= R_STOP;
                        end else begin
                            rx_scnt <= rx_scnt + SW'(1);
                        end
                    end
`endif
                    R_STOP: begin
                        if (rx_scnt == OS_LAST) begin
                            rx_scnt  <= '0;
                            rx_state <= R_IDLE;
                            if (rxs != STOP_LEVEL) frame_err <= 1'b1;
                        end else begin
                            rx_scnt <= rx_scnt + SW'(1);
                        end
                    end
                    default: rx_state <= R_IDLE;
                endcase
            end
        end
    end

    // Transmitter.
    tx_state_t            tx_state;
    logic [SW-1:0]        tx_scnt;
    logic [BW-1:0]        tx_bcnt;
    logic [DATA_BITS-1:0] tx_sh;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    assign tx_pop_c = (tx_state == T_IDLE) && !fifo_empty;

    // TX FSM; TxD is registered so it changes one cycle after each decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= T_IDLE;
            tx_scnt  <= '0;
            tx_bcnt  <= '0;
            tx_sh    <= '0;
            TxD      <= IDLE_LEVEL;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (tx_pop_c) begin
                        tx_sh    <= fifo_dout;
                        tx_scnt  <= '0;
                        tx_bcnt  <= '0;
                        TxD      <= START_LEVEL;
                        tx_state <= T_START;
`ifdef UART_PARITY_EN
                        tx_par   <= parity_bit(MAX_DATA_BITS'(fifo_dout), 1'(PARITY_ODD));
`endif
                    end
                end
                T_START: begin
                    if (tick_c) begin
                        if (tx_scnt == OS_LAST) begin
                            tx_scnt  <= '0;
                            TxD      <= tx_sh[0];
                            tx_state <= T_DATA;
                        end else begin
                            tx_scnt <= tx_scnt + SW'(1);
                        end
                    end
                end
                T_DATA: begin
                    if (tick_c) begin
                        if (tx_scnt == OS_LAST) begin
                            tx_scnt <= '0;
                            if (tx_bcnt == BIT_LAST) begin
`ifdef UART_PARITY_EN
                                TxD      <= tx_par;
                                tx_state <= T_PAR;
`else
                                TxD      <= STOP_LEVEL;
                                tx_state <= T_STOP;
`endif
                            end else begin
                                tx_bcnt <= tx_bcnt + BW'(1);
                                tx_sh   <= tx_sh >> 1;
                                TxD     <= tx_sh[1];
                            end
                        end else begin
                            tx_scnt <= tx_scnt + SW'(1);
                        end
                    end
                end
`ifdef UART_PARITY_EN
                T_PAR: begin
                    if (tick_c) begin
                        if (tx_scnt == OS_LAST) begin
                            tx_scnt  <= '0;
                            TxD      <= STOP_LEVEL;
                            tx_state <= T_STOP;
                        end else begin
                            tx_scnt <= tx_scnt + SW'(1);
                        end
                    end
                end
`endif
                T_STOP: begin
                    if (tick_c) begin
                        if (tx_scnt == OS_LAST) begin
                            tx_scnt  <= '0;
                            tx_state <= T_IDLE;
                        end else begin
                            tx_scnt <= tx_scnt + SW'(1);
                        end
                    end
                end
                default: begin
                    tx_state <= T_IDLE;
                    TxD      <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
Parametrised UART transceiver that echoes received bytes back out on TxD through an on-chip FIFO.
- Successor to the fixed receiver-to-transmitter pairing.
- Adds configurable baud, data width and buffer depth.
- Adds oversampled, glitch-filtered reception and sticky error reporting.
- Sits at the board-facing edge of the design, directly on the serial pins.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency.
BAUD, 9600, line rate. DIV = CLK_FREQ_HZ/(BAUD*OVERSAMPLE), truncated, must be >= 2.
OVERSAMPLE, 16, ticks per bit. Must be even and >= 4.
DATA_BITS, 8, payload bits per frame, 5..9, LSB first.
FIFO_DEPTH, 16, entries. Power of two, >= 2.
PARITY_ODD, 0, parity sense: 1 = odd, 0 = even. Only used when UART_PARITY_EN is defined.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
RxD  in  1  serial input; asynchronous, idle high.
TxD  out  1  serial output; idle high.
clr_err  in  1  single-cycle pulse; clears all sticky error flags.
frame_err  out  1  sticky; a stop bit was sampled low.
rx_overrun  out  1  sticky; a byte arrived while the FIFO was full.
parity_err  out  1  sticky; a parity bit mismatched. Tied 0 without UART_PARITY_EN.
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset values (all outputs): TxD=1, frame_err=0, rx_overrun=0, parity_err=0, fifo_count=0.
- Reset clears all FSMs, the tick counter and FIFO pointers.
- Reset mid-frame: TxD returns high the cycle after reset is sampled; any partial RX byte is discarded.
- Tick generator: counter 0..DIV-1. Emits a one-cycle tick when the count hits DIV-1, then wraps to 0. Free-running after reset.
- RxD passes through a 2-flop synchroniser, reset to 1. All RX logic uses the synchronised value, rxs.
- RX FSM, states R_IDLE, R_START, R_DATA, R_PAR, R_STOP:
  - R_IDLE: rxs==0 on a tick -> R_START, sample counter cleared.
  - R_START: at tick OVERSAMPLE/2-1, if rxs==1 the start was a glitch -> R_IDLE; else -> R_DATA.
  - R_DATA: samples at mid-bit, i.e. every OVERSAMPLE ticks. After DATA_BITS samples -> R_PAR if parity is enabled, else R_STOP.
  - R_STOP, mid-bit sample:
    - 1 with no parity error: push the byte. If the FIFO is full, drop it and set rx_overrun.
    - 0: set frame_err and drop the byte.
    - Either way -> R_IDLE. No push on any error.
- TX FSM, states T_IDLE, T_START, T_DATA, T_PAR, T_STOP:
  - T_IDLE: when the FIFO is non-empty, pop and latch the word; TxD=0 from the next cycle.
  - Each bit lasts exactly OVERSAMPLE ticks.
  - Stop bit is one bit time high, then T_IDLE. Back-to-back frames have no extra idle gap.
- Echo latency: RX push in cycle T -> FIFO non-empty visible in T+1 -> TX pops in T+1 -> TxD falls in T+2.
- FIFO, registered:
  - Full with push and pop in the same cycle: both are performed and count is unchanged.
  - Empty with push: pop is gated by !empty, so only the push happens.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: set on their event and held until clr_err or reset. If clr_err and a new error occur in the same cycle, the flag ends up set.

Optional Feature:
UART_PARITY_EN defined:
- One parity bit follows the data bits; parity is even if PARITY_ODD=0, else odd.
- RX checks it in R_PAR. On mismatch it sets parity_err and the byte is not pushed. The stop bit is still checked.
- TX generates the parity bit in T_PAR.

UART_PARITY_EN undefined:
- Frame is 1 start + DATA_BITS + 1 stop.
- R_PAR and T_PAR are unreachable; parity_err is constant 0.

Decomposition:
- Package uart_pkg holds:
  - RX and TX state typedef enums.
  - Constants IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1.
  - Parity helper function (XOR-reduce plus PARITY_ODD).
- One sub-module: uart_sync_fifo (parameters WIDTH=DATA_BITS, DEPTH=FIFO_DEPTH). Ports push/pop/din/dout/full/empty/count.
- The RX FSM, TX FSM and tick generator stay in uart_echo_fifo.

Test Plan:
All tests use CLK_FREQ_HZ=1600000, BAUD=10000, OVERSAMPLE=16, DATA_BITS=8, FIFO_DEPTH=4, so DIV=10 and 1 bit = 160 clk.
1. Single echo: drive byte 0xA5 on RxD.
   -> TxD produces start, 1,0,1,0,0,1,0,1, stop, 0xA5 LSB first. fifo_count returns to 0; no flags set.
2. Glitch: RxD low for 40 clk, then high.
   -> No push, fifo_count stays 0, TxD stays 1.
3. Framing: send 0x3C with stop bit driven 0.
   -> frame_err=1, no echo. A clr_err pulse then clears it to 0.
4. Overrun: send 6 back-to-back bytes 0x01..0x06 while holding the bench TX check.
   -> TX is continuously draining, so assert the echoed sequence and rx_overrun per a reference model. Additional case with tx paused via force: the 5th byte is dropped and rx_overrun=1.
5. Reset mid-frame: assert reset at bit 4 of an outgoing 0xFF.
   -> TxD=1 next cycle, fifo_count=0, and the next received byte 0x5A echoes cleanly.
6. With UART_PARITY_EN and PARITY_ODD=0: send 0x07 with parity bit 0 (wrong).
   -> parity_err=1, no echo. Send 0x07 with parity 1 -> echoed with parity bit 1.
